// File: rtl/spi_reg_seq.sv
// Frames each SPI chip-select window into a command byte plus a data burst and
// drives the register mux/demux with qualified strobes, auto-increment and error guards.
//
// state | meaning
// IDLE  | waiting for an armed cs_n falling window
// CMD   | waiting for the command byte (R/W + 7-bit address)
// WDATA | write burst, each rxdv becomes a write strobe
// RDATA | read burst, each tx_ready becomes a transmit load
// ERR   | frame aborted, wait for cs_n high
module spi_reg_seq #(
    parameter int unsigned BURST_MAX = 64,
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [7:0]  INC_MASK  = 8'b1101_0111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       rxdv,
    input  logic [7:0] rx_d,
    input  logic       tx_ready,
    input  logic       tx_en_in,
    input  logic [7:0] tx_d_in,
    output logic [6:0] reg_addr,
    output logic       addr_dv,
    output logic       rw_out,
    output logic       rxdv_out,
    output logic [7:0] rx_d_out,
    output logic       tx_load,
    output logic [7:0] tx_byte,
    output logic       rd_strobe,
    output logic [6:0] byte_cnt,
    output logic       busy,
    output logic       err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, ERR} state_t;

    state_t         state_q, state_d;
    logic           armed_q, armed_d;
    logic [6:0]     reg_addr_q, reg_addr_d;
    logic           addr_dv_q, addr_dv_d;
    logic           rw_q, rw_d;
    logic           rxdv_out_q, rxdv_out_d;
    logic [7:0]     rx_d_out_q, rx_d_out_d;
    logic           tx_load_q, tx_load_d;
    logic [7:0]     tx_byte_q, tx_byte_d;
    logic           rd_strobe_q, rd_strobe_d;
    logic [6:0]     byte_cnt_q, byte_cnt_d;
    logic           err_q, err_d;
    logic [TW-1:0]  tmr_q, tmr_d;

    logic rx_ev, tx_ev, active, timed_out, burst_full;

    // A byte coinciding with cs_n high belongs to a dying frame and is dropped.
    assign rx_ev      = rxdv & ~cs_n;
    assign tx_ev      = tx_ready & ~cs_n;
    assign active     = (state_q == CMD) || (state_q == WDATA) || (state_q == RDATA);
    assign timed_out  = active && (tmr_q == '0) && !cs_n && !rxdv && !tx_ready;
    assign burst_full = (byte_cnt_q == 7'(BURST_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            reg_addr_q  <= '0;
            addr_dv_q   <= 1'b0;
            rw_q        <= 1'b0;
            rxdv_out_q  <= 1'b0;
            rx_d_out_q  <= '0;
            tx_load_q   <= 1'b0;
            tx_byte_q   <= 8'h00;
            rd_strobe_q <= 1'b0;
            byte_cnt_q  <= '0;
            err_q       <= 1'b0;
            tmr_q       <= TW'(TIMEOUT);
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            reg_addr_q  <= reg_addr_d;
            addr_dv_q   <= addr_dv_d;
            rw_q        <= rw_d;
            rxdv_out_q  <= rxdv_out_d;
            rx_d_out_q  <= rx_d_out_d;
            tx_load_q   <= tx_load_d;
            tx_byte_q   <= tx_byte_d;
            rd_strobe_q <= rd_strobe_d;
            byte_cnt_q  <= byte_cnt_d;
            err_q       <= err_d;
            tmr_q       <= tmr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q | cs_n;
        reg_addr_d  = reg_addr_q;
        addr_dv_d   = addr_dv_q;
        rw_d        = rw_q;
        rxdv_out_d  = 1'b0;
        rx_d_out_d  = rx_d_out_q;
        tx_load_d   = 1'b0;
        tx_byte_d   = tx_byte_q;
        rd_strobe_d = 1'b0;
        byte_cnt_d  = byte_cnt_q;
        err_d       = err_q;
        tmr_d       = tmr_q;

        if (cs_n || rxdv || tx_ready) begin
            tmr_d = TW'(TIMEOUT);
        end else if (active && (tmr_q != '0)) begin
            tmr_d = tmr_q - 1'b1;
        end

        // Increment lands one cycle after the strobe so the strobe sees the old address.
        if ((rxdv_out_q || tx_load_q) && INC_MASK[reg_addr_q[2:0]]) begin
            reg_addr_d = reg_addr_q + 7'd1;
        end

        case (state_q)
            IDLE: begin
                if (!cs_n && armed_q) begin
                    state_d = CMD;
                    armed_d = 1'b0;
                end
            end
            CMD: begin
                if (timed_out) begin
                    err_d     = 1'b1;
                    addr_dv_d = 1'b0;
                    state_d   = ERR;
                end else if (rx_ev) begin
                    reg_addr_d = rx_d[6:0];
                    rw_d       = rx_d[7];
                    err_d      = 1'b0;
                    byte_cnt_d = '0;
                    addr_dv_d  = 1'b1;
                    state_d    = rx_d[7] ? RDATA : WDATA;
                end
            end
            WDATA: begin
                if (timed_out || (rx_ev && burst_full)) begin
                    err_d     = 1'b1;
                    addr_dv_d = 1'b0;
                    state_d   = ERR;
                end else if (rx_ev) begin
                    rxdv_out_d = 1'b1;
                    rx_d_out_d = rx_d;
                    byte_cnt_d = byte_cnt_q + 7'd1;
                end
            end
            RDATA: begin
                if (timed_out || (tx_ev && burst_full)) begin
                    err_d     = 1'b1;
                    addr_dv_d = 1'b0;
                    state_d   = ERR;
                end else if (tx_ev) begin
                    tx_load_d   = 1'b1;
                    rd_strobe_d = 1'b1;
                    tx_byte_d   = tx_en_in ? tx_d_in : 8'hFF;
                    err_d       = err_q | ~tx_en_in;
                    byte_cnt_d  = byte_cnt_q + 7'd1;
                end
            end
            ERR: begin
                addr_dv_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cs_n) begin
            state_d   = IDLE;
            addr_dv_d = 1'b0;
            rw_d      = 1'b0;
        end
    end

    assign reg_addr  = reg_addr_q;
    assign addr_dv   = addr_dv_q;
    assign rw_out    = rw_q;
    assign rxdv_out  = rxdv_out_q;
    assign rx_d_out  = rx_d_out_q;
    assign tx_load   = tx_load_q;
    assign tx_byte   = tx_byte_q;
    assign rd_strobe = rd_strobe_q;
    assign byte_cnt  = byte_cnt_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_spi_reg_seq.sv
// Scoreboarded bench for spi_reg_seq: expected strobes are queued as bytes are
// driven and matched against the DUT's write/read strobes as they appear.
module tb_spi_reg_seq;

    localparam logic [7:0] INC_MASK = 8'b1101_0111;

    logic       clk = 1'b0;
    logic       reset, cs_n, rxdv, tx_ready, tx_en_in;
    logic [7:0] rx_d, tx_d_in;
    logic [6:0] reg_addr, byte_cnt;
    logic       addr_dv, rw_out, rxdv_out, tx_load, rd_strobe, busy, err;
    logic [7:0] rx_d_out, tx_byte;

    always #5 clk = ~clk;

    spi_reg_seq #(.BURST_MAX(64), .TIMEOUT(1024), .INC_MASK(INC_MASK)) dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .rxdv(rxdv), .rx_d(rx_d),
        .tx_ready(tx_ready), .tx_en_in(tx_en_in), .tx_d_in(tx_d_in),
        .reg_addr(reg_addr), .addr_dv(addr_dv), .rw_out(rw_out),
        .rxdv_out(rxdv_out), .rx_d_out(rx_d_out), .tx_load(tx_load),
        .tx_byte(tx_byte), .rd_strobe(rd_strobe), .byte_cnt(byte_cnt),
        .busy(busy), .err(err)
    );

    int errors = 0;
    int checks = 0;
    logic [14:0] wr_q[$];
    logic [14:0] rd_q[$];
    logic [14:0] mon_e;
    logic [6:0]  m_addr;

    // Scoreboard: every write/read strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (rxdv_out) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr=%h data=%h, required no strobe", reg_addr, rx_d_out);
            end else begin
                mon_e = wr_q.pop_front();
                if ({reg_addr, rx_d_out} !== mon_e) begin
                    errors++;
                    $display("FAIL wr_data: got addr=%h data=%h, required addr=%h data=%h",
                             reg_addr, rx_d_out, mon_e[14:8], mon_e[7:0]);
                end
            end
        end
        if (tx_load) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got addr=%h byte=%h, required no load", reg_addr, tx_byte);
            end else begin
                mon_e = rd_q.pop_front();
                if ({reg_addr, tx_byte} !== mon_e) begin
                    errors++;
                    $display("FAIL rd_data: got addr=%h byte=%h, required addr=%h byte=%h",
                             reg_addr, tx_byte, mon_e[14:8], mon_e[7:0]);
                end
            end
        end
        if (tx_load || rd_strobe) begin
            checks++;
            if (rd_strobe !== tx_load) begin
                errors++;
                $display("FAIL rd_strobe_align: got rd_strobe=%b tx_load=%b, required equal", rd_strobe, tx_load);
            end
        end
        if (rxdv_out || tx_load) begin
            checks++;
            if (addr_dv !== 1'b1) begin
                errors++;
                $display("FAIL strobe_addr_dv: got addr_dv=%b, required 1", addr_dv);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic push_wr(input logic [7:0] d);
        wr_q.push_back({m_addr, d});
        if (INC_MASK[m_addr[2:0]]) m_addr = m_addr + 7'd1;
    endtask

    task automatic push_rd(input logic [7:0] d, input logic en);
        rd_q.push_back({m_addr, en ? d : 8'hFF});
        if (INC_MASK[m_addr[2:0]]) m_addr = m_addr + 7'd1;
    endtask

    task automatic frame_start();
        @(negedge clk) cs_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk) cs_n = 1'b1;
        @(negedge clk);
        chk("end_addr_dv", {7'd0, addr_dv}, 8'd0);
        chk("end_busy", {7'd0, busy}, 8'd0);
        @(negedge clk);
    endtask

    task automatic cmd(input logic [7:0] b);
        m_addr = b[6:0];
        @(negedge clk) begin rxdv = 1'b1; rx_d = b; end
        @(negedge clk) rxdv = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wr_data(input logic [7:0] d, input logic exp_strobe);
        @(negedge clk) begin rxdv = 1'b1; rx_d = d; end
        @(negedge clk) rxdv = 1'b0;
        chk("wr_latency", {7'd0, rxdv_out}, {7'd0, exp_strobe});
        repeat (2) @(negedge clk);
    endtask

    task automatic rd_data(input logic [7:0] d, input logic en, input logic exp_load);
        @(negedge clk) begin tx_ready = 1'b1; tx_en_in = en; tx_d_in = d; end
        @(negedge clk) tx_ready = 1'b0;
        chk("rd_latency", {7'd0, tx_load}, {7'd0, exp_load});
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_reg_addr", {1'b0, reg_addr}, 8'd0);
        chk("rst_byte_cnt", {1'b0, byte_cnt}, 8'd0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_flags", {1'b0, addr_dv, rw_out, rxdv_out, tx_load, rd_strobe, busy, err}, 8'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_idle_busy", {7'd0, busy}, 8'd0);
    endtask

    task automatic test_single_write();
        frame_start();
        cmd(8'h06);
        chk("sw_addr_dv", {7'd0, addr_dv}, 8'd1);
        chk("sw_rw", {7'd0, rw_out}, 8'd0);
        chk("sw_reg_addr", {1'b0, reg_addr}, 8'h06);
        push_wr(8'hA5);
        wr_data(8'hA5, 1'b1);
        chk("sw_byte_cnt", {1'b0, byte_cnt}, 8'd1);
        frame_end();
    endtask

    task automatic test_burst_write();
        logic [7:0] d[3] = '{8'h11, 8'h22, 8'h33};
        frame_start();
        cmd(8'h00);
        for (int i = 0; i < 3; i++) begin
            push_wr(d[i]);
            wr_data(d[i], 1'b1);
        end
        chk("bw_byte_cnt", {1'b0, byte_cnt}, 8'd3);
        frame_end();
    endtask

    task automatic test_hold_addr();
        frame_start();
        cmd(8'h03);
        for (int i = 0; i < 4; i++) begin
            push_wr(8'hC0 + 8'(i));
            wr_data(8'hC0 + 8'(i), 1'b1);
        end
        chk("hold_reg_addr", {1'b0, reg_addr}, 8'h03);
        frame_end();
    endtask

    task automatic test_read();
        logic [7:0] d[3] = '{8'h5A, 8'h5B, 8'h5C};
        frame_start();
        cmd(8'h81);
        chk("rd_rw", {7'd0, rw_out}, 8'd1);
        for (int i = 0; i < 3; i++) begin
            push_rd(d[i], 1'b1);
            rd_data(d[i], 1'b1, 1'b1);
        end
        chk("rd_err", {7'd0, err}, 8'd0);
        frame_end();
    endtask

    task automatic test_read_err();
        frame_start();
        cmd(8'hFF);
        push_rd(8'h33, 1'b0);
        rd_data(8'h33, 1'b0, 1'b1);
        chk("rde_err", {7'd0, err}, 8'd1);
        chk("rde_wrap", {1'b0, reg_addr}, 8'h00);
        push_rd(8'h44, 1'b1);
        rd_data(8'h44, 1'b1, 1'b1);
        frame_end();
        chk("rde_err_sticky", {7'd0, err}, 8'd1);
        frame_start();
        cmd(8'h02);
        chk("rde_err_clear", {7'd0, err}, 8'd0);
        frame_end();
    endtask

    task automatic test_reset_mid();
        frame_start();
        cmd(8'h05);
        push_wr(8'h5A);
        wr_data(8'h5A, 1'b1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        wr_data(8'h66, 1'b0);
        wr_data(8'h67, 1'b0);
        chk("rm_busy", {7'd0, busy}, 8'd0);
        frame_end();
        frame_start();
        cmd(8'h04);
        push_wr(8'h77);
        wr_data(8'h77, 1'b1);
        frame_end();
    endtask

    task automatic test_timeout();
        frame_start();
        cmd(8'h01);
        repeat (1000) @(negedge clk);
        chk("to_early_err", {7'd0, err}, 8'd0);
        chk("to_early_dv", {7'd0, addr_dv}, 8'd1);
        repeat (100) @(negedge clk);
        chk("to_err", {7'd0, err}, 8'd1);
        chk("to_addr_dv", {7'd0, addr_dv}, 8'd0);
        chk("to_busy", {7'd0, busy}, 8'd1);
        wr_data(8'h12, 1'b0);
        frame_end();
    endtask

    task automatic test_burst_limit();
        frame_start();
        cmd(8'h03);
        for (int i = 0; i < 64; i++) begin
            push_wr(8'(i));
            wr_data(8'(i), 1'b1);
        end
        chk("bl_byte_cnt", {1'b0, byte_cnt}, 8'd64);
        chk("bl_err_before", {7'd0, err}, 8'd0);
        wr_data(8'hFE, 1'b0);
        chk("bl_err", {7'd0, err}, 8'd1);
        chk("bl_addr_dv", {7'd0, addr_dv}, 8'd0);
        frame_end();
    endtask

    task automatic test_back_to_back();
        frame_start();
        cmd(8'h00);
        push_wr(8'hAA);
        push_wr(8'hBB);
        @(negedge clk) begin rxdv = 1'b1; rx_d = 8'hAA; end
        @(negedge clk) rx_d = 8'hBB;
        @(negedge clk) rxdv = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b_byte_cnt", {1'b0, byte_cnt}, 8'd2);
        push_wr(8'hDD);
        @(negedge clk) begin rxdv = 1'b1; tx_ready = 1'b1; rx_d = 8'hDD; tx_en_in = 1'b1; end
        @(negedge clk) begin rxdv = 1'b0; tx_ready = 1'b0; end
        chk("b2b_both_sel", {6'd0, rxdv_out, tx_load}, 8'b10);
        repeat (2) @(negedge clk);
        @(negedge clk) begin rxdv = 1'b1; rx_d = 8'hCC; cs_n = 1'b1; end
        @(negedge clk) rxdv = 1'b0;
        chk("b2b_cs_discard", {7'd0, rxdv_out}, 8'd0);
        chk("b2b_cnt_hold", {1'b0, byte_cnt}, 8'd3);
        chk("b2b_addr_dv", {7'd0, addr_dv}, 8'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; cs_n = 1'b1; rxdv = 1'b0; rx_d = 8'h00;
        tx_ready = 1'b0; tx_en_in = 1'b0; tx_d_in = 8'h00; m_addr = '0;
        test_reset();
        test_single_write();
        test_burst_write();
        test_hold_addr();
        test_read();
        test_read_err();
        test_reset_mid();
        test_timeout();
        test_burst_limit();
        test_back_to_back();
        checks++;
        if (wr_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d wr and %0d rd left, required 0", wr_q.size(), rd_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
